// File: rtl/vc_arbiter_ctrl.sv
// vc_arbiter_ctrl: QoS control FSM, weighted VC0/VC1 arbitration and 2-stage routing to D0/D1
module vc_arbiter_ctrl #(
  parameter int BW = 6,
  parameter int TH_W = 4,
  parameter int WEIGHT = 3
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            init,
  input  logic [TH_W-1:0] umbral_vc_low_in,
  input  logic [TH_W-1:0] umbral_vc_high_in,
  input  logic [TH_W-1:0] umbral_d_low_in,
  input  logic [TH_W-1:0] umbral_d_high_in,
  input  logic            VC0_empty,
  input  logic            VC1_empty,
  input  logic            VC0_almost_empty,
  input  logic            VC1_almost_empty,
  input  logic [BW-1:0]   VC0_data_out,
  input  logic [BW-1:0]   VC1_data_out,
  input  logic            D0_almost_full,
  input  logic            D1_almost_full,
  input  logic            D0_full,
  input  logic            D1_full,
  input  logic            D0_empty,
  input  logic            D1_empty,
  input  logic [3:0]      fifo_error,
  output logic [TH_W-1:0] umbral_vc_low,
  output logic [TH_W-1:0] umbral_vc_high,
  output logic [TH_W-1:0] umbral_d_low,
  output logic [TH_W-1:0] umbral_d_high,
  output logic            VC0_rd,
  output logic            VC1_rd,
  output logic            D0_push,
  output logic            D1_push,
  output logic [BW-1:0]   data_out,
  output logic [4:0]      state,
  output logic            idle_out,
  output logic            active_out,
  output logic            error_out
);
  localparam int CW = $clog2(WEIGHT + 1);
  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TH_W-1:0] vc_low_q, vc_low_d, vc_high_q, vc_high_d, d_low_q, d_low_d, d_high_q, d_high_d;
  logic [BW-1:0] data_q, data_d, word;
  logic rd0_q, rd0_d, rd1_q, rd1_d, push0_q, push0_d, push1_q, push1_d;
  logic v1_q, v1_d, sel1_q, sel1_d;
  logic idle_q, idle_d, active_q, active_d, error_q, error_d;
  logic err, pipe_busy, el0, el1, can, g0, g1;
  logic unused_status;
  assign unused_status = D0_empty ^ D1_empty;
  always_comb begin
    err = state_q != S_RESET && (|fifo_error || (push0_q && D0_full) || (push1_q && D1_full));
    pipe_busy = rd0_q | rd1_q | v1_q;
    state_d = state_q == S_RESET ? S_INIT :
              (err || state_q == S_ERROR) ? S_ERROR :
              state_q == S_INIT ? (init ? S_INIT : S_IDLE) :
              init ? S_INIT :
              state_q == S_IDLE ? ((!VC0_empty || !VC1_empty) ? S_ACTIVE : S_IDLE) :
              (VC0_empty && VC1_empty && !pipe_busy) ? S_IDLE : S_ACTIVE;
    // a VC whose last word is already being read is not eligible again
    el0 = !VC0_empty && !(rd0_q && VC0_almost_empty);
    el1 = !VC1_empty && !(rd1_q && VC1_almost_empty);
    can = state_q == S_ACTIVE && state_d == S_ACTIVE && !D0_almost_full && !D1_almost_full;
    g1 = can && el1 && (!el0 || cnt_q == CW'(WEIGHT));
    g0 = can && el0 && !g1;
    cnt_d = (!el1 || g1) ? '0 : g0 ? cnt_q + CW'(1) : cnt_q;
    rd0_d = g0;
    rd1_d = g1;
    v1_d = rd0_q | rd1_q;
    sel1_d = rd1_q;
    word = sel1_q ? VC1_data_out : VC0_data_out;
    data_d = v1_q ? word : data_q;
    push0_d = v1_q && !word[BW-1];
    push1_d = v1_q && word[BW-1];
    vc_low_d = state_q == S_INIT ? umbral_vc_low_in : vc_low_q;
    vc_high_d = state_q == S_INIT ? umbral_vc_high_in : vc_high_q;
    d_low_d = state_q == S_INIT ? umbral_d_low_in : d_low_q;
    d_high_d = state_q == S_INIT ? umbral_d_high_in : d_high_q;
    idle_d = state_d == S_IDLE;
    active_d = state_d == S_ACTIVE;
    error_d = state_d == S_ERROR;
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= S_RESET;
      cnt_q <= '0;
      rd0_q <= 1'b0;
      rd1_q <= 1'b0;
      v1_q <= 1'b0;
      sel1_q <= 1'b0;
      data_q <= '0;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      vc_low_q <= '0;
      vc_high_q <= '0;
      d_low_q <= '0;
      d_high_q <= '0;
      idle_q <= 1'b0;
      active_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      v1_q <= v1_d;
      sel1_q <= sel1_d;
      data_q <= data_d;
      push0_q <= push0_d;
      push1_q <= push1_d;
      vc_low_q <= vc_low_d;
      vc_high_q <= vc_high_d;
      d_low_q <= d_low_d;
      d_high_q <= d_high_d;
      idle_q <= idle_d;
      active_q <= active_d;
      error_q <= error_d;
    end
  end
  assign state = state_q;
  assign VC0_rd = rd0_q;
  assign VC1_rd = rd1_q;
  assign D0_push = push0_q;
  assign D1_push = push1_q;
  assign data_out = data_q;
  assign umbral_vc_low = vc_low_q;
  assign umbral_vc_high = vc_high_q;
  assign umbral_d_low = d_low_q;
  assign umbral_d_high = d_high_q;
  assign idle_out = idle_q;
  assign active_out = active_q;
  assign error_out = error_q;
endmodule
